// File: rtl/ice_idver_regbank.sv
// ICE ID/version window plus capability/control register bank on the ICE debug bus.
// Latency: request accepted in cycle N, ICEACK/ICEDO/ICEERR presented in N+2 only.
// Backpressure: one outstanding access; strobes arriving while busy (N+1, N+2) are dropped.
module ice_idver_regbank #(
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter logic [ADDR_W-1:0] IDVER_BASE    = 32'h0880_8000,
  parameter logic [ADDR_W-1:0] CAP_BASE      = 32'h0880_4000,
  parameter logic [DATA_W-1:0] FNAVAIL_RST   = 32'h0000_0003,
  parameter logic [DATA_W-1:0] FNAVAIL_WMASK = 32'h0000_0003
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IDVER,
  input  logic [ADDR_W-1:0] ICEIFA,
  input  logic              ICERD,
  input  logic              ICEWR,
  input  logic [DATA_W-1:0] ICEDI,
  output logic [DATA_W-1:0] ICEDO,
  output logic              ICEACK,
  output logic              ICEERR,
  output logic [DATA_W-1:0] FNAVAIL
);

  // Register offsets inside the capability window.
  localparam logic [11:0] OFF_SCRATCH = 12'h000;
  localparam logic [11:0] OFF_FNAVAIL = 12'h008;
  localparam logic [11:0] OFF_ACCCNT  = 12'h00C;
  localparam logic [11:0] OFF_ERRCNT  = 12'h010;

  // Access sequencing: IDLE accepts (cycle N), HOLD is N+1, RESP is N+2.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              accept;
  logic              resp;

  logic [DATA_W-1:0] idver_q;
  logic [DATA_W-1:0] scratch;
  logic [DATA_W-1:0] fnavail_q;
  logic [DATA_W-1:0] acccnt;
  logic [DATA_W-1:0] errcnt;

  logic [DATA_W-1:0] rsp_dat;
  logic              rsp_err;

  logic              req;
  logic              hit_idver;
  logic              hit_cap;
  logic [11:0]       offset;
  logic              off_mapped;
  logic              acc_err;
  logic              acc_legal;
  logic [DATA_W-1:0] rd_dat;

  logic              wr_scratch;
  logic              wr_fnavail;
  logic              clr_acccnt;
  logic              clr_errcnt;

  // Address decode and error classification of the request presented this cycle.
  always_comb begin
    req        = ICERD | ICEWR;
    hit_idver  = (ICEIFA[ADDR_W-1:12] == IDVER_BASE[ADDR_W-1:12]);
    hit_cap    = (ICEIFA[ADDR_W-1:12] == CAP_BASE[ADDR_W-1:12]);
    offset     = ICEIFA[11:0];
    off_mapped = (offset == OFF_SCRATCH) || (offset == OFF_FNAVAIL) ||
                 (offset == OFF_ACCCNT)  || (offset == OFF_ERRCNT);
    // Simultaneous read+write, unmapped address, hole in the cap map and
    // writes to the read-only ID window are all reported as errors.
    acc_err    = (ICERD & ICEWR) ||
                 !(hit_idver || hit_cap) ||
                 (hit_cap && !off_mapped) ||
                 (hit_idver && ICEWR);
    acc_legal  = !acc_err;
  end

  // Read mux: sampled at accept, so reads observe pre-access register values.
  always_comb begin
    rd_dat = '0;
    if (hit_idver) begin
      rd_dat = idver_q;
    end else begin
      case (offset)
        OFF_SCRATCH: rd_dat = scratch;
        OFF_FNAVAIL: rd_dat = fnavail_q;
        OFF_ACCCNT:  rd_dat = acccnt;
        OFF_ERRCNT:  rd_dat = errcnt;
        default:     rd_dat = '0;
      endcase
    end
  end

  // Register write enables; only legal, accepted writes have any effect.
  always_comb begin
    wr_scratch = 1'b0;
    wr_fnavail = 1'b0;
    clr_acccnt = 1'b0;
    clr_errcnt = 1'b0;
    if (accept && acc_legal && ICEWR && hit_cap) begin
      wr_scratch = (offset == OFF_SCRATCH);
      wr_fnavail = (offset == OFF_FNAVAIL);
      clr_acccnt = (offset == OFF_ACCCNT);
      clr_errcnt = (offset == OFF_ERRCNT);
    end
  end

  // Access state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; accept only from IDLE so strobes while busy are ignored.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    resp      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          accept    = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bus outputs are forced to zero outside the response cycle so ICEDO can be OR-merged.
  always_comb begin
    ICEACK  = resp;
    ICEERR  = resp & rsp_err;
    ICEDO   = resp ? rsp_dat : '0;
    FNAVAIL = fnavail_q;
  end

  // Strap word pipeline register; reads see IDVER delayed by one cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      idver_q <= '0;
    end else begin
      idver_q <= IDVER;
    end
  end

  // Response capture at accept; writes and errors return zero data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rsp_dat <= '0;
      rsp_err <= 1'b0;
    end else if (accept) begin
      rsp_err <= acc_err;
      rsp_dat <= (acc_err || ICEWR) ? '0 : rd_dat;
    end
  end

  // SCRATCH: plain full-width read/write register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      scratch <= '0;
    end else if (wr_scratch) begin
      scratch <= ICEDI;
    end
  end

  // FNAVAIL: only masked bits are writable, the rest keep their reset value.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fnavail_q <= FNAVAIL_RST;
    end else if (wr_fnavail) begin
      fnavail_q <= (ICEDI & FNAVAIL_WMASK) | (FNAVAIL_RST & ~FNAVAIL_WMASK);
    end
  end

  // ACCCNT: wrapping count of legal accesses; the clearing write is not counted.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      acccnt <= '0;
    end else if (clr_acccnt) begin
      acccnt <= '0;
    end else if (accept && acc_legal) begin
      acccnt <= acccnt + DATA_W'(1);
    end
  end

  // ERRCNT: saturating count of error accesses, cleared by any write to it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      errcnt <= '0;
    end else if (clr_errcnt) begin
      errcnt <= '0;
    end else if (accept && acc_err && (errcnt != '1)) begin
      errcnt <= errcnt + DATA_W'(1);
    end
  end

endmodule

// File: tb/tb_ice_idver_regbank.sv
// Self-checking bench for ice_idver_regbank: directed scenarios plus randomized accesses
// compared against a register-level reference model of the ICE register bank.
module tb_ice_idver_regbank;

  logic        CLK;
  logic        RESET;
  logic [31:0] IDVER;
  logic [31:0] ICEIFA;
  logic        ICERD;
  logic        ICEWR;
  logic [31:0] ICEDI;
  logic [31:0] ICEDO;
  logic        ICEACK;
  logic        ICEERR;
  logic [31:0] FNAVAIL;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model state
  logic [31:0] m_scr, m_fn, m_acc, m_err;

  // Observations from the last do_access call
  logic        obs_n1_ack;
  logic [31:0] obs_n1_dat;
  logic [31:0] obs_n1_fn;
  logic        obs_ack;
  logic        obs_err;
  logic [31:0] obs_dat;
  logic        exp_err;
  logic [31:0] exp_dat;

  ice_idver_regbank dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .IDVER   (IDVER),
    .ICEIFA  (ICEIFA),
    .ICERD   (ICERD),
    .ICEWR   (ICEWR),
    .ICEDI   (ICEDI),
    .ICEDO   (ICEDO),
    .ICEACK  (ICEACK),
    .ICEERR  (ICEERR),
    .FNAVAIL (FNAVAIL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #5000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  task automatic model_reset();
    m_scr = 32'h0;
    m_fn  = 32'h3;
    m_acc = 32'h0;
    m_err = 32'h0;
  endtask

  // Register-bank semantics: decide the outcome, then apply the side effects.
  task automatic model_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, output logic e, output logic [31:0] q);
    bit in_id, in_cap, mapped;
    in_id  = (a[31:12] == 20'h08808);
    in_cap = (a[31:12] == 20'h08804);
    mapped = (a[11:0] == 12'h000) || (a[11:0] == 12'h008) ||
             (a[11:0] == 12'h00C) || (a[11:0] == 12'h010);
    e = (rd && wr) || !(in_id || in_cap) || (in_cap && !mapped) || (in_id && wr);
    q = 32'h0;
    if (e) begin
      if (m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
      return;
    end
    if (rd) begin
      if (in_id)                  q = IDVER;
      else if (a[11:0] == 12'h000) q = m_scr;
      else if (a[11:0] == 12'h008) q = m_fn;
      else if (a[11:0] == 12'h00C) q = m_acc;
      else                         q = m_err;
      m_acc = m_acc + 1;
    end else begin
      if (a[11:0] == 12'h000) m_scr = d;
      if (a[11:0] == 12'h008) m_fn  = d & 32'h3;
      if (a[11:0] == 12'h010) m_err = 32'h0;
      if (a[11:0] == 12'h00C) m_acc = 32'h0;
      else                    m_acc = m_acc + 1;
    end
  endtask

  // Drives one access starting at the next negedge and records N+1 / N+2 observations.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    model_access(rd, wr, a, d, exp_err, exp_dat);
    @(negedge CLK);
    ICERD = rd; ICEWR = wr; ICEIFA = a; ICEDI = d;
    @(negedge CLK);
    obs_n1_ack = ICEACK; obs_n1_dat = ICEDO; obs_n1_fn = FNAVAIL;
    ICERD = 1'b0; ICEWR = 1'b0;
    @(negedge CLK);
    obs_ack = ICEACK; obs_err = ICEERR; obs_dat = ICEDO;
  endtask

  function automatic logic [65:0] obs();
    return {obs_n1_ack, obs_n1_dat, obs_ack, obs_err, obs_dat};
  endfunction

  task automatic apply_reset();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    chk_cnt++;
    if ({ICEACK, ICEERR, ICEDO, FNAVAIL} !== {1'b0, 1'b0, 32'h0, 32'h3})
      $display("FAIL reset_outputs got=%h exp=%h", {ICEACK, ICEERR, ICEDO, FNAVAIL}, {1'b0, 1'b0, 32'h0, 32'h3});
    else pass_cnt++;
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    do_access(1'b1, 1'b0, 32'h0880_400C, 32'h0);
    chk_cnt++;
    if (obs() !== {1'b0, 32'h0, 1'b1, 1'b0, 32'h0})
      $display("FAIL reset_acccnt got=%h exp=%h", obs(), {1'b0, 32'h0, 1'b1, 1'b0, 32'h0});
    else pass_cnt++;
    do_access(1'b1, 1'b0, 32'h0880_4000, 32'h0);
    chk_cnt++;
    if (obs() !== {1'b0, 32'h0, 1'b1, 1'b0, 32'h0})
      $display("FAIL reset_scratch got=%h exp=%h", obs(), {1'b0, 32'h0, 1'b1, 1'b0, 32'h0});
    else pass_cnt++;
  endtask

  task automatic test_idver_read();
    IDVER = 32'h1234_5678;
    do_access(1'b1, 1'b0, 32'h0880_8ABC, 32'h0);
    chk_cnt++;
    if (obs() !== {1'b0, 32'h0, 1'b1, 1'b0, 32'h1234_5678})
      $display("FAIL idver_read got=%h exp=%h", obs(), {1'b0, 32'h0, 1'b1, 1'b0, 32'h1234_5678});
    else pass_cnt++;
    @(negedge CLK);
    chk_cnt++;
    if ({ICEACK, ICEDO} !== {1'b0, 32'h0})
      $display("FAIL idver_after_ack got=%h exp=%h", {ICEACK, ICEDO}, {1'b0, 32'h0});
    else pass_cnt++;
  endtask

  task automatic test_fnavail();
    do_access(1'b0, 1'b1, 32'h0880_4008, 32'hFFFF_FFFC);
    chk_cnt++;
    if ({obs(), obs_n1_fn} !== {1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0})
      $display("FAIL fnavail_clear got=%h exp=%h", {obs(), obs_n1_fn}, {1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0});
    else pass_cnt++;
    do_access(1'b0, 1'b1, 32'h0880_4008, 32'hFFFF_FFFF);
    chk_cnt++;
    if (obs_n1_fn !== 32'h3)
      $display("FAIL fnavail_mask got=%h exp=%h", obs_n1_fn, 32'h3);
    else pass_cnt++;
    do_access(1'b1, 1'b0, 32'h0880_4008, 32'h0);
    chk_cnt++;
    if (obs() !== {1'b0, 32'h0, 1'b1, 1'b0, 32'h3})
      $display("FAIL fnavail_readback got=%h exp=%h", obs(), {1'b0, 32'h0, 1'b1, 1'b0, 32'h3});
    else pass_cnt++;
  endtask

  task automatic test_acccnt();
    apply_reset();
    do_access(1'b0, 1'b1, 32'h0880_4000, 32'h0000_0011);
    do_access(1'b1, 1'b0, 32'h0880_4000, 32'h0);
    do_access(1'b0, 1'b1, 32'h0880_4008, 32'h0000_0002);
    do_access(1'b1, 1'b0, 32'h0880_8000, 32'h0);
    do_access(1'b1, 1'b0, 32'h0880_400C, 32'h0);
    chk_cnt++;
    if (obs() !== {1'b0, 32'h0, 1'b1, 1'b0, 32'h4})
      $display("FAIL acccnt_four got=%h exp=%h", obs(), {1'b0, 32'h0, 1'b1, 1'b0, 32'h4});
    else pass_cnt++;
    do_access(1'b0, 1'b1, 32'h0880_400C, 32'h1234);
    do_access(1'b1, 1'b0, 32'h0880_400C, 32'h0);
    chk_cnt++;
    if (obs() !== {1'b0, 32'h0, 1'b1, 1'b0, 32'h0})
      $display("FAIL acccnt_clear got=%h exp=%h", obs(), {1'b0, 32'h0, 1'b1, 1'b0, 32'h0});
    else pass_cnt++;
  endtask

  task automatic test_errors();
    logic        rds [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic        wrs [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] adr [4] = '{32'h0880_8000, 32'h0880_4004, 32'h0900_0000, 32'h0880_4000};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      do_access(rds[i], wrs[i], adr[i], 32'hDEAD_BEEF);
      chk_cnt++;
      if (obs() !== {1'b0, 32'h0, 1'b1, 1'b1, 32'h0})
        $display("FAIL error_access_%0d got=%h exp=%h", i, obs(), {1'b0, 32'h0, 1'b1, 1'b1, 32'h0});
      else pass_cnt++;
    end
    do_access(1'b1, 1'b0, 32'h0880_4010, 32'h0);
    chk_cnt++;
    if (obs() !== {1'b0, 32'h0, 1'b1, 1'b0, 32'h4})
      $display("FAIL errcnt_four got=%h exp=%h", obs(), {1'b0, 32'h0, 1'b1, 1'b0, 32'h4});
    else pass_cnt++;
    do_access(1'b1, 1'b0, 32'h0880_400C, 32'h0);
    chk_cnt++;
    if (obs_dat !== 32'h1)
      $display("FAIL acccnt_after_errors got=%h exp=%h", obs_dat, 32'h1);
    else pass_cnt++;
    do_access(1'b1, 1'b0, 32'h0880_4000, 32'h0);
    chk_cnt++;
    if (obs_dat !== 32'h0)
      $display("FAIL scratch_after_errors got=%h exp=%h", obs_dat, 32'h0);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic e;
    logic [31:0] q;
    model_access(1'b0, 1'b1, 32'h0880_4000, 32'h1, e, q);
    @(negedge CLK);
    ICEWR = 1'b1; ICEIFA = 32'h0880_4000; ICEDI = 32'h1;
    @(negedge CLK);
    chk_cnt++;
    if (ICEACK !== 1'b0) $display("FAIL b2b_n1 got=%b exp=0", ICEACK);
    else pass_cnt++;
    ICEDI = 32'h2;
    @(negedge CLK);
    chk_cnt++;
    if ({ICEACK, ICEERR, ICEDO} !== {1'b1, 1'b0, 32'h0})
      $display("FAIL b2b_n2 got=%h exp=%h", {ICEACK, ICEERR, ICEDO}, {1'b1, 1'b0, 32'h0});
    else pass_cnt++;
    ICEDI = 32'h3;
    @(negedge CLK);
    chk_cnt++;
    if (ICEACK !== 1'b0) $display("FAIL b2b_n3 got=%b exp=0", ICEACK);
    else pass_cnt++;
    model_access(1'b1, 1'b0, 32'h0880_4000, 32'h0, e, q);
    ICEWR = 1'b0; ICERD = 1'b1;
    @(negedge CLK);
    chk_cnt++;
    if (ICEACK !== 1'b0) $display("FAIL b2b_n4 got=%b exp=0", ICEACK);
    else pass_cnt++;
    ICERD = 1'b0;
    @(negedge CLK);
    chk_cnt++;
    if ({ICEACK, ICEERR, ICEDO} !== {1'b1, 1'b0, 32'h1})
      $display("FAIL b2b_n5 got=%h exp=%h", {ICEACK, ICEERR, ICEDO}, {1'b1, 1'b0, 32'h1});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_access();
    do_access(1'b0, 1'b1, 32'h0880_4008, 32'h0);
    chk_cnt++;
    if (obs_n1_fn !== 32'h0) $display("FAIL mid_reset_setup got=%h exp=%h", obs_n1_fn, 32'h0);
    else pass_cnt++;
    @(negedge CLK);
    ICEWR = 1'b1; ICEIFA = 32'h0880_4000; ICEDI = 32'hA5A5_A5A5;
    @(negedge CLK);
    ICEWR = 1'b0; RESET = 1'b1;
    @(negedge CLK);
    chk_cnt++;
    if (ICEACK !== 1'b0) $display("FAIL mid_reset_n2 got=%b exp=0", ICEACK);
    else pass_cnt++;
    RESET = 1'b0;
    model_reset();
    @(negedge CLK);
    chk_cnt++;
    if ({ICEACK, FNAVAIL} !== {1'b0, 32'h3})
      $display("FAIL mid_reset_n3 got=%h exp=%h", {ICEACK, FNAVAIL}, {1'b0, 32'h3});
    else pass_cnt++;
    do_access(1'b1, 1'b0, 32'h0880_4000, 32'h0);
    chk_cnt++;
    if (obs() !== {1'b0, 32'h0, 1'b1, 1'b0, 32'h0})
      $display("FAIL mid_reset_scratch got=%h exp=%h", obs(), {1'b0, 32'h0, 1'b1, 1'b0, 32'h0});
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [11:0] offs [5] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010};
    logic [31:0] a;
    logic        rd, wr;
    int          sel, kind;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) IDVER = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0)      a = {20'h08808, 12'($urandom)};
      else if (sel <= 5) a = {20'h08804, offs[sel-1]};
      else if (sel == 6) a = $urandom;
      else               a = 32'h0900_0000;
      kind = $urandom_range(0, 9);
      rd = (kind <= 4) || (kind == 9);
      wr = (kind >= 5);
      do_access(rd, wr, a, $urandom);
      chk_cnt++;
      if ({obs(), obs_n1_fn} !== {1'b0, 32'h0, 1'b1, exp_err, exp_dat, m_fn})
        $display("FAIL random_%0d a=%h rd=%b wr=%b got=%h exp=%h", i, a, rd, wr,
                 {obs(), obs_n1_fn}, {1'b0, 32'h0, 1'b1, exp_err, exp_dat, m_fn});
      else pass_cnt++;
    end
  endtask

  initial begin
    RESET = 1'b1; IDVER = 32'h0; ICEIFA = 32'h0; ICERD = 1'b0; ICEWR = 1'b0; ICEDI = 32'h0;
    model_reset();
    test_reset();
    test_idver_read();
    test_fnavail();
    test_acccnt();
    test_errors();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
